// File: rtl/kmeans_pkg.sv
// Shared types for the K-means seed picker: index width, default seed count, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a. FILL state exists only when SEED_PICKER_FALLBACK_EN is defined.
package kmeans_pkg;

  localparam int IDX_W = 13;
  localparam int K_DEF = 4;

  typedef logic [IDX_W-1:0] seed_idx_t;

`ifdef SEED_PICKER_FALLBACK_EN
  typedef enum logic [2:0] {
    S_IDLE, S_DRAW, S_CHECK, S_EMIT, S_DONE, S_ERR, S_FILL
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_DRAW, S_CHECK, S_EMIT, S_DONE, S_ERR
  } state_t;
`endif

endpackage

// File: rtl/seed_dup_check.sv
// Parallel compare of one candidate index against the first `count` seed slots.
// Latency: purely combinational.
// Backpressure: none; slots at or beyond count never match.
module seed_dup_check
  import kmeans_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int CNT_W = $clog2(K_DEF + 1)
) (
  input  seed_idx_t          cand,
  input  seed_idx_t [K-1:0]  slots,
  input  logic [CNT_W-1:0]   count,
  output logic               dup
);

  // OR together every match among the occupied slots
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < K; i++) begin
      if ((CNT_W'(i) < count) && (slots[i] == cand)) begin
        dup = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kmeans_seed_picker.sv
// Draws K distinct in-range point indices from a free-running random source for K-means seeding.
// Latency: start->first idx_valid 3 cycles minimum; 3 cycles per index with idx_ready high.
// Backpressure: idx/idx_valid hold in EMIT until idx_ready; optional FILL fallback via SEED_PICKER_FALLBACK_EN.
module kmeans_seed_picker
  import kmeans_pkg::*;
#(
  parameter int K         = K_DEF,
  parameter int MAX_TRIES = 1024
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  seed_idx_t num_points,
  input  seed_idx_t rnd,
  output seed_idx_t idx,
  output logic      idx_valid,
  input  logic      idx_ready,
  output logic      busy,
  output logic      done,
  output logic      err
);

  localparam int               CNT_W     = $clog2(K + 1);
  localparam int               TRY_W     = $clog2(MAX_TRIES) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(K - 1);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

  state_t            state, state_nxt;
  seed_idx_t         n_q;
  seed_idx_t         cand_q;
  seed_idx_t         chk_val;
  seed_idx_t [K-1:0] slots;
  logic [CNT_W-1:0]  count;
  logic [TRY_W-1:0]  tries, tries_inc;
  logic              dup, in_range, accept, exhausted, last_seed;

`ifdef SEED_PICKER_FALLBACK_EN
  seed_idx_t         fill_ptr;
  logic              fill_mode;

  // FILL reuses the duplicate checker on its ascending pointer
  assign chk_val = (state == S_FILL) ? fill_ptr : cand_q;
`else
  assign chk_val = cand_q;
`endif

  seed_dup_check #(
    .K     (K),
    .CNT_W (CNT_W)
  ) u_dup (
    .cand  (chk_val),
    .slots (slots),
    .count (count),
    .dup   (dup)
  );

  assign in_range  = (chk_val < n_q);
  assign accept    = in_range && !dup;
  assign tries_inc = tries + TRY_W'(1);
  assign exhausted = (tries_inc == TRY_LIMIT);
  assign last_seed = (count == LAST_CNT);

  // state register; reset aborts any run without a done/err pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (num_points == '0) ? S_ERR : S_DRAW;
      S_DRAW:  state_nxt = S_CHECK;
      S_CHECK: begin
        if (accept) begin
          state_nxt = S_EMIT;
        end else if (exhausted) begin
`ifdef SEED_PICKER_FALLBACK_EN
          state_nxt = S_FILL;
`else
          state_nxt = S_ERR;
`endif
        end else begin
          state_nxt = S_DRAW;
        end
      end
      S_EMIT: begin
        if (idx_ready) begin
`ifdef SEED_PICKER_FALLBACK_EN
          state_nxt = last_seed ? S_DONE : (fill_mode ? S_FILL : S_DRAW);
`else
          state_nxt = last_seed ? S_DONE : S_DRAW;
`endif
        end
      end
`ifdef SEED_PICKER_FALLBACK_EN
      // pointer is monotonic, so running past N means no legal index remains
      S_FILL:  state_nxt = !in_range ? S_ERR : (accept ? S_EMIT : S_FILL);
`endif
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // datapath: latched N, candidate, seed slots, counters and the output index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q       <= '0;
      cand_q    <= '0;
      idx       <= '0;
      count     <= '0;
      tries     <= '0;
      slots     <= '0;
`ifdef SEED_PICKER_FALLBACK_EN
      fill_ptr  <= '0;
      fill_mode <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n_q   <= num_points;
            count <= '0;
            tries <= '0;
`ifdef SEED_PICKER_FALLBACK_EN
            fill_ptr  <= '0;
            fill_mode <= 1'b0;
`endif
          end
        end
        S_DRAW: cand_q <= rnd;
        S_CHECK: begin
          if (accept) begin
            for (int i = 0; i < K; i++) begin
              if (CNT_W'(i) == count) slots[i] <= cand_q;
            end
            idx <= cand_q;
          end else begin
            tries <= tries_inc;
`ifdef SEED_PICKER_FALLBACK_EN
            if (exhausted) fill_mode <= 1'b1;
`endif
          end
        end
        S_EMIT: begin
          if (idx_ready) count <= count + CNT_W'(1);
        end
`ifdef SEED_PICKER_FALLBACK_EN
        S_FILL: begin
          if (in_range) begin
            fill_ptr <= fill_ptr + 1'b1;
            if (!dup) begin
              for (int i = 0; i < K; i++) begin
                if (CNT_W'(i) == count) slots[i] <= fill_ptr;
              end
              idx <= fill_ptr;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the state
  always_comb begin
    idx_valid = (state == S_EMIT);
    done      = (state == S_DONE);
    err       = (state == S_ERR);
    case (state)
      S_DRAW, S_CHECK, S_EMIT: busy = 1'b1;
`ifdef SEED_PICKER_FALLBACK_EN
      S_FILL:                  busy = 1'b1;
`endif
      default:                 busy = 1'b0;
    endcase
  end

endmodule
